// File: rtl/matrix_column_scanner.sv
// Time-multiplexed 7x5 LED matrix scanner: latches a whole image per frame and drives one column
// per dwell. Define MATRIX_SCAN_BLANKING_EN to darken the first BLANK_CYCLES of every dwell.
module matrix_column_scanner #(
    parameter int unsigned CLOCK_DIV    = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [6:0] column_4,
    input  logic [6:0] column_3,
    input  logic [6:0] column_2,
    input  logic [6:0] column_1,
    input  logic [6:0] column_0,
    output logic [6:0] rows,
    output logic [4:0] columns,
    output logic       frame_start
);

    localparam int unsigned DivW = $clog2(CLOCK_DIV);
    localparam logic [DivW-1:0] DivMax = DivW'(CLOCK_DIV - 1);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e          state_q, state_d;
    logic [2:0]      col_idx_q, col_idx_d;
    logic [DivW-1:0] div_count_q, div_count_d;
    logic [6:0]      frame_buf_q [5];
    logic [6:0]      frame_buf_d [5];
    logic            capture;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            col_idx_q   <= 3'd4;
            div_count_q <= '0;
            for (int i = 0; i < 5; i++) begin
                frame_buf_q[i] <= 7'h7f;
            end
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            div_count_q <= div_count_d;
            for (int i = 0; i < 5; i++) begin
                frame_buf_q[i] <= frame_buf_d[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        div_count_d = div_count_q;
        capture     = 1'b0;
        unique case (state_q)
            StIdle: begin
                col_idx_d   = 3'd4;
                div_count_d = '0;
                if (enable) begin
                    state_d = StScan;
                    capture = 1'b1;
                end
            end
            StScan: begin
                if (!enable) begin
                    state_d     = StIdle;
                    col_idx_d   = 3'd4;
                    div_count_d = '0;
                end else if (div_count_q == DivMax) begin
                    div_count_d = '0;
                    // Frame boundary: restart at column 4 with a freshly latched image
                    if (col_idx_q == 3'd0) begin
                        col_idx_d = 3'd4;
                        capture   = 1'b1;
                    end else begin
                        col_idx_d = col_idx_q - 3'd1;
                    end
                end else begin
                    div_count_d = div_count_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        for (int i = 0; i < 5; i++) begin
            frame_buf_d[i] = frame_buf_q[i];
        end
        if (capture) begin
            frame_buf_d[4] = column_4;
            frame_buf_d[3] = column_3;
            frame_buf_d[2] = column_2;
            frame_buf_d[1] = column_1;
            frame_buf_d[0] = column_0;
        end
    end

    // Outputs depend on registered state only, never on the live inputs
    always_comb begin
        rows        = 7'h7f;
        columns     = 5'b00000;
        frame_start = 1'b0;
        if (state_q == StScan) begin
            rows        = frame_buf_q[col_idx_q];
            columns     = 5'b00001 << col_idx_q;
            frame_start = (col_idx_q == 3'd4) && (div_count_q == '0);
`ifdef MATRIX_SCAN_BLANKING_EN
            if (32'(div_count_q) < BLANK_CYCLES) begin
                rows    = 7'h7f;
                columns = 5'b00000;
            end
`endif
        end
    end

endmodule
